regfile_wb_arbiter: RTL

Write-back controller for the 32×32 register file. It owns the register file's single write port (`reg_write`, `rd`, `write_data`) and shares it between two requesters, the ALU result path and the load/memory path, using valid/ready handshakes and round-robin arbitration. After every reset it first sequences a clear sweep that writes zero to registers 1..NREG-1. It sits between the execute/memory stages and the register file.

---
 rtl/regfile_wb_arbiter_if.sv | 27 ++
 rtl/regfile_wb_arbiter.sv | 91 +++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Write-request handshake bundle between the two write-back sources (ALU, memory)
// and the register-file write-back arbiter.
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    // valid/ready: a request transfers on a cycle where valid && ready; the source
    // must hold rd/data stable while valid && !ready, and ready never looks at its own valid.
    logic              a_valid;
    logic              a_ready;
    logic [ADDR_W-1:0] a_rd;
    logic [DATA_W-1:0] a_data;
    logic              m_valid;
    logic              m_ready;
    logic [ADDR_W-1:0] m_rd;
    logic [DATA_W-1:0] m_data;

    modport master (
        output a_valid, a_rd, a_data, m_valid, m_rd, m_data,
        input  a_ready, m_ready
    );

    modport slave (
        input  a_valid, a_rd, a_data, m_valid, m_rd, m_data,
        output a_ready, m_ready
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Owns the register file write port: clears x1..x(NREG-1) after reset, then
// round-robins ALU and memory write-backs onto a registered write port.
module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREG   = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    regfile_wb_arbiter_if.slave wb,
    output logic                reg_write,
    output logic [ADDR_W-1:0]   rd,
    output logic [DATA_W-1:0]   write_data,
    output logic                init_busy,
    output logic [1:0]          dbg_state
);

    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;
    typedef enum logic {PRIO_A = 1'b0, PRIO_M = 1'b1} prio_t;

    state_t            state, state_nxt;
    prio_t             prio, prio_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;
    logic              reg_write_nxt;
    logic [ADDR_W-1:0] rd_nxt;
    logic [DATA_W-1:0] write_data_nxt;
    logic              a_fire, m_fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_INIT;
            prio       <= PRIO_A;
            cnt        <= ADDR_W'(1);
            reg_write  <= 1'b0;
            rd         <= '0;
            write_data <= '0;
        end else begin
            state      <= state_nxt;
            prio       <= prio_nxt;
            cnt        <= cnt_nxt;
            reg_write  <= reg_write_nxt;
            rd         <= rd_nxt;
            write_data <= write_data_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        prio_nxt       = prio;
        cnt_nxt        = cnt;
        reg_write_nxt  = 1'b0;
        rd_nxt         = rd;
        write_data_nxt = write_data;
        wb.a_ready     = 1'b0;
        wb.m_ready     = 1'b0;
        a_fire         = 1'b0;
        m_fire         = 1'b0;

        case (state)
            ST_INIT: begin
                reg_write_nxt  = 1'b1;
                rd_nxt         = cnt;
                write_data_nxt = '0;
                cnt_nxt        = cnt + 1'b1;
                if (cnt == ADDR_W'(NREG - 1)) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                // Only the prioritised source can block the other, so grants are exclusive.
                wb.a_ready = !(wb.m_valid && prio == PRIO_M);
                wb.m_ready = !(wb.a_valid && prio == PRIO_A);
                a_fire     = wb.a_valid && wb.a_ready;
                m_fire     = wb.m_valid && wb.m_ready;
                if (a_fire) begin
                    reg_write_nxt  = (wb.a_rd != '0);
                    rd_nxt         = wb.a_rd;
                    write_data_nxt = wb.a_data;
                    prio_nxt       = PRIO_M;
                end else if (m_fire) begin
                    reg_write_nxt  = (wb.m_rd != '0);
                    rd_nxt         = wb.m_rd;
                    write_data_nxt = wb.m_data;
                    prio_nxt       = PRIO_A;
                end
            end
        endcase
    end

    assign init_busy = (state == ST_INIT);
    assign dbg_state = {prio, state};

endmodule
